// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Valid/ready on both sides; results held in DONE until consumed.
module booth_seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN,
      DONE
   } state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;
   logic             r_dz_out;
   logic             r_ov_out;
   logic             r_sa;
   logic             r_sb;
   logic             r_dz;
   logic             r_ov;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;
   logic             w_last;

   // Trial subtraction is one bit wider so |MIN_NEG| survives intact
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_abs_a = dividend[WIDTH-1] ? ~dividend + 1'b1 : dividend;
   assign w_abs_b = divisor[WIDTH-1]  ? ~divisor + 1'b1  : divisor;
   assign w_q_fin = (r_sa ^ r_sb) ? ~r_quo + 1'b1 : r_quo;
   assign w_r_fin = r_sa ? ~r_rem + 1'b1 : r_rem;
   assign w_last  = (r_cnt == CW'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_q_out     <= '0;
         r_r_out     <= '0;
         r_dz_out    <= 1'b0;
         r_ov_out    <= 1'b0;
         r_sa        <= 1'b0;
         r_sb        <= 1'b0;
         r_dz        <= 1'b0;
         r_ov        <= 1'b0;
         r_a         <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_sa       <= dividend[WIDTH-1];
                  r_sb       <= divisor[WIDTH-1];
                  r_a        <= dividend;
                  r_quo      <= w_abs_a;
                  r_dvs      <= w_abs_b;
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_dz       <= (divisor == '0);
                  r_ov       <= (dividend == MIN_NEG) && (divisor == '1);
                  r_in_ready <= 1'b0;
                  r_state    <= (divisor == '0) ? SIGN : CALC;
               end
            end
            CALC: begin
               if (!w_diff[WIDTH]) begin
                  r_rem <= w_diff[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
               if (w_last) r_state <= SIGN;
            end
            SIGN: begin
               if (r_dz) begin
                  r_q_out <= '1;
                  r_r_out <= r_a;
               end else if (r_ov) begin
                  r_q_out <= MIN_NEG;
                  r_r_out <= '0;
               end else begin
                  r_q_out <= w_q_fin;
                  r_r_out <= w_r_fin;
               end
               r_dz_out    <= r_dz;
               r_ov_out    <= r_ov && !r_dz;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_dz_out    <= 1'b0;
                  r_ov_out    <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign quotient    = r_q_out;
   assign remainder   = r_r_out;
   assign div_by_zero = r_dz_out;
   assign overflow    = r_ov_out;

endmodule
